// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_pkg;
  localparam int unsigned ITER_W = 6;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
endpackage

// File: rtl/addsub32.sv
// 32-bit add/subtract with carry-out and signed overflow; sub=1 computes a - b.
module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum_c,
  output logic        carry_c,
  output logic        ovf_c
);
  logic [31:0] bx;

  assign bx               = b ^ {32{sub}};
  assign {carry_c, sum_c} = {1'b0, a} + {1'b0, bx} + {32'b0, sub};
  assign ovf_c            = (a[31] == bx[31]) && (sum_c[31] != a[31]);
endmodule

// File: rtl/multdiv.sv
// Radix-2 Booth multiply / restoring divide, one bit per cycle on a shared adder.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  state_t            state, state_next;
  logic [ITER_W-1:0] cnt, cnt_next;
  logic [31:0]       acc, acc_next;
  logic [31:0]       lo, lo_next;
  logic [31:0]       opa, opa_next;
  logic              pm1, pm1_next;
  logic              neg_q, neg_q_next;
  logic              ovf_case, ovf_case_next;
  logic [31:0]       result_next;
  logic              exc_next, rdy_next;

  logic [31:0]       as_a, as_b, as_sum;
  logic              as_sub, as_carry, as_ovf;

  logic              last;
  logic [1:0]        booth;
  logic              booth_op;
  logic [31:0]       rem_sh;
  logic [32:0]       prod_top;
  logic [31:0]       booth_hi;
  logic              booth_msb;

  assign last     = (cnt == ITER_W'(ITER));
  assign booth    = {lo[0], pm1};
  assign booth_op = (booth == 2'b01) || (booth == 2'b10);
  assign rem_sh   = {acc[30:0], lo[31]};
  assign prod_top = {acc, lo[31]};

  addsub32 u_addsub (
    .a      (as_a),
    .b      (as_b),
    .sub    (as_sub),
    .sum_c  (as_sum),
    .carry_c(as_carry),
    .ovf_c  (as_ovf)
  );

  // Adder operand select: dividend negation on start, Booth/trial step, quotient negation at the end.
  always_comb begin
    as_a   = acc;
    as_b   = opa;
    as_sub = 1'b0;
    case (state)
      IDLE, DONE: begin
        as_a   = '0;
        as_b   = data_operandA;
        as_sub = 1'b1;
      end
      MULT: begin
        as_sub = (booth == 2'b10);
      end
      DIV: begin
        if (last) begin
          as_a   = '0;
          as_b   = lo;
          as_sub = 1'b1;
        end else begin
          // A negative divisor is added instead of subtracted, so |B| is never formed.
          as_a   = rem_sh;
          as_sub = ~opa[31];
        end
      end
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    acc_next      = acc;
    lo_next       = lo;
    opa_next      = opa;
    pm1_next      = pm1;
    neg_q_next    = neg_q;
    ovf_case_next = ovf_case;
    result_next   = data_result;
    exc_next      = data_exception;
    rdy_next      = 1'b0;
    booth_hi      = acc;
    booth_msb     = acc[31];

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (ctrl_MULT) begin
          state_next = MULT;
          cnt_next   = '0;
          acc_next   = '0;
          lo_next    = data_operandB;
          pm1_next   = 1'b0;
          opa_next   = data_operandA;
        end else if (ctrl_DIV) begin
          state_next    = DIV;
          cnt_next      = '0;
          acc_next      = '0;
          lo_next       = data_operandA[31] ? as_sum : data_operandA;
          opa_next      = data_operandB;
          neg_q_next    = data_operandA[31] ^ data_operandB[31];
          ovf_case_next = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
        end
      end

      MULT: begin
        if (last) begin
          state_next  = DONE;
          cnt_next    = '0;
          rdy_next    = 1'b1;
          result_next = lo;
          exc_next    = !((prod_top == '0) || (prod_top == '1));
        end else begin
          // Overflow-corrected sign keeps the shifted product exact for INT_MIN operands.
          if (booth_op) begin
            booth_hi  = as_sum;
            booth_msb = as_sum[31] ^ as_ovf;
          end
          acc_next = {booth_msb, booth_hi[31:1]};
          lo_next  = {booth_hi[0], lo[31:1]};
          pm1_next = lo[0];
          cnt_next = cnt + ITER_W'(1);
        end
      end

      DIV: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
          rdy_next   = 1'b1;
          if (opa == '0) begin
            result_next = '0;
            exc_next    = 1'b1;
          end else begin
            result_next = neg_q ? as_sum : lo;
            exc_next    = ovf_case;
          end
        end else begin
          if (as_carry) begin
            acc_next = as_sum;
            lo_next  = {lo[30:0], 1'b1};
          end else begin
            acc_next = rem_sh;
            lo_next  = {lo[30:0], 1'b0};
          end
          cnt_next = cnt + ITER_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      lo             <= '0;
      opa            <= '0;
      pm1            <= 1'b0;
      neg_q          <= 1'b0;
      ovf_case       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      acc            <= acc_next;
      lo             <= lo_next;
      opa            <= opa_next;
      pm1            <= pm1_next;
      neg_q          <= neg_q_next;
      ovf_case       <= ovf_case_next;
      data_result    <= result_next;
      data_exception <= exc_next;
      data_resultRDY <= rdy_next;
    end
  end
endmodule

// File: tb/tb_multdiv.sv
// Randomized self-checking bench for multdiv against an arithmetic reference model.
module tb_multdiv;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  multdiv #(.ITER(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic void model_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit e);
    longint p;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  // Cycle-level model: expected strobe/result/exception after every clock edge.
  bit          model_ok = 1'b0;
  bit          pend = 1'b0;
  bit          busy;
  int          s_edge = 0;
  logic [31:0] p_res, m_res = '0;
  bit          p_exc, m_exc = 1'b0, m_rdy = 1'b0;

  always @(posedge clock) begin
    cyc++;
    busy = pend;
    if (reset) begin
      pend = 1'b0; m_rdy = 1'b0; m_res = '0; m_exc = 1'b0; model_ok = 1'b1;
    end else begin
      m_rdy = 1'b0;
      if (pend && cyc == s_edge) begin
        m_rdy = 1'b1; m_res = p_res; m_exc = p_exc; pend = 1'b0;
      end
      if (!busy && (ctrl_MULT || ctrl_DIV)) begin
        model_op(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
        s_edge = cyc + 33;
        pend = 1'b1;
      end
    end
    #1;
    if (model_ok) begin
      checks += 3;
      if (data_resultRDY !== m_rdy) begin
        errors++; $display("FAIL cyc_rdy cycle %0d got %b want %b", cyc, data_resultRDY, m_rdy);
      end
      if (data_result !== m_res) begin
        errors++; $display("FAIL cyc_result cycle %0d got %h want %h", cyc, data_result, m_res);
      end
      if (data_exception !== m_exc) begin
        errors++; $display("FAIL cyc_exc cycle %0d got %b want %b", cyc, data_exception, m_exc);
      end
    end
  end

  task automatic chk_model(input string name, input bit m, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input bit ee);
    logic [31:0] r;
    bit e;
    model_op(m, a, b, r, e);
    checks++;
    if (r !== er || e !== ee) begin
      errors++; $display("FAIL model_%s got %h/%b want %h/%b", name, r, e, er, ee);
    end
  endtask

  // Called at a negedge; launches an op sampled at the next edge and waits for its strobe.
  task automatic run_op(input string name, input bit m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit ee, input int div_at, input bit noise);
    int s;
    bit seen;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = ~m;
    @(negedge clock);
    s = cyc;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        seen = 1'b1;
        break;
      end
      if (div_at > 0 && cyc + 1 == s + div_at) ctrl_DIV = 1'b1;
      if (noise) begin
        data_operandA = $urandom;
        data_operandB = $urandom;
        if ($urandom_range(0, 9) == 0) ctrl_MULT = 1'b1;
        if ($urandom_range(0, 9) == 0) ctrl_DIV = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_timeout got no strobe want strobe at +33", name);
    end else if (cyc - s != 33) begin
      errors++; $display("FAIL %s_latency got %0d want 33", name, cyc - s);
    end
    checks++;
    if (data_result !== er || data_exception !== ee) begin
      errors++;
      $display("FAIL %s_value got %h/%b want %h/%b", name, data_result, data_exception, er, ee);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'h1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($signed($urandom_range(0, 200)) - 100);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, rr;
    bit re, rm;

    chk_model("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    chk_model("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    chk_model("div_100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    chk_model("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0, 1'b0);
    run_op("mul_big", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 0, 1'b0);
    run_op("mul_min", 1'b1, 32'h8000_0000, 32'h1, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("div_100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 0, 1'b0);
    run_op("div_by0", 1'b0, 32'd5, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b0);
    run_op("mul_ignore_div", 1'b1, 32'd1000, 32'd1000, 32'd1000000, 1'b0, 10, 1'b0);
    repeat (36) @(negedge clock);

    // Reset at E12 of a multiply, with a start pulse coincident with reset.
    data_operandA = 32'd123;
    data_operandB = 32'd456;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%b/%b want 0/0/0", data_result, data_exception,
               data_resultRDY);
    end
    repeat (40) @(negedge clock);
    run_op("mul_6x6", 1'b1, 32'd6, 32'd6, 32'd36, 1'b0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rm = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      model_op(rm, ra, rb, rr, re);
      run_op("rand", rm, ra, rb, rr, re, 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multdiv.md
# multdiv

Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage. It sits beside the ALU and takes the same decoded operands. It raises a one-cycle ready pulse when its result is available for writeback. The pipeline stalls while the unit is busy. A single shared 32-bit add/subtract datapath iterates one bit per cycle for both operations.

## Interface
Parameters:
- ITER, 32, iterations per operation (equal to the operand width)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- data_operandA  in  32  multiplicand / dividend, two's complement
- data_operandB  in  32  multiplier / divisor, two's complement
- ctrl_MULT  in  1  one-cycle start pulse for multiply
- ctrl_DIV  in  1  one-cycle start pulse for divide
- data_result  out  32  low product word or quotient
- data_exception  out  1  overflow or divide fault, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle result strobe

One clock. Reset is synchronous and active-high.

## Operation
- FSM states:
  - IDLE: start accepted
  - MULT: iterating a multiply
  - DIV: iterating a divide
  - DONE: strobe cycle; start also accepted here
- Start handling:
  - Operands and ctrl are sampled on the same edge.
  - If ctrl_MULT and ctrl_DIV are both high, MULT wins.
  - Start pulses in MULT or DIV are ignored.
- Multiply: radix-2 Booth. The 65-bit product register is {32'b0, B, 1'b0}. Each step adds, subtracts or passes A into the upper 32 bits based on the low two bits, then arithmetic-shifts right by one.
  - data_result = product[31:0].
  - data_exception = 1 when product[63:31] is not all zeros and not all ones.
- Divide: restoring division on magnitudes.
  - Quotient sign = A[31] XOR B[31]; the quotient truncates toward zero.
  - Remainder is discarded.
  - B == 0: data_result = 0, data_exception = 1.
  - A == 0x80000000 and B == 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
  - Fault cases keep the normal latency; the FSM still counts ITER cycles.
- data_result and data_exception are registered. They hold their values until the next operation completes.
- Reset values: data_result = 0, data_exception = 0, data_resultRDY = 0, state = IDLE, counter = 0.

## Timing
- Start sampled at edge E0.
- Iterations occur on edges E1..E32.
- Result registers load and data_resultRDY rises at edge E33.
- data_resultRDY is high for exactly one cycle and falls at E34.
- Latency is 33 cycles from the start edge to the strobe, identical for every operation including fault cases.
- Back-to-back: a start sampled at E34 (the DONE cycle) begins the next operation. There is no idle bubble.
- Reset asserted at any edge:
  - The current operation is aborted with no strobe.
  - All outputs are 0 on the following cycle.
  - A start coincident with reset is dropped.
- Operand inputs may change freely after E0; only the latched copies are used.

## Structure
- Package multdiv_pkg holds:
  - the state enum {IDLE, MULT, DIV, DONE}
  - ITER_W = 6 (counter width)
  - the two fault constants INT_MIN and NEG_ONE
- One sub-module, addsub32: 32-bit adder with a sub control, shared by the Booth step and the restoring trial subtract.
- Magnitude conversion and final negation reuse addsub32 in the first and last cycles; no extra adders.

## Test plan
- Multiply 7 × −3 pulsed at E0 → data_resultRDY only at E33, data_result = 0xFFFFFFEB, data_exception = 0.
- Multiply 0x00010000 × 0x00010000 → data_result = 0x00000000, data_exception = 1. Multiply 0x80000000 × 1 → 0x80000000, data_exception = 0.
- Divide −7 / 2 → 0xFFFFFFFD with no exception. Divide 100 / −7 → 0xFFFFFFF2 with no exception.
- Divide 5 / 0 → data_result = 0, data_exception = 1, strobe at E33. Divide 0x80000000 / 0xFFFFFFFF → 0x80000000, data_exception = 1.
- ctrl_DIV pulsed at E10 during a multiply → ignored; the multiply result arrives at E33 and no second strobe follows. A start in the DONE cycle yields the next strobe exactly 33 cycles later.
- Reset at E12 of a multiply → no strobe, all outputs 0. A subsequent 6 × 6 returns 36 with normal latency.
